// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited program fetch with in-order prefetch FIFO, branch flush and stall.
// In-flight responses at a redirect are dropped via the discard counter.
module instr_fetch #(
   parameter int            AW       = 8,
   parameter int            DW       = 8,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          ce,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] ir,
   output logic          ir_valid,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_take,
   input  logic          br_load,
   input  logic [AW-1:0] br_target
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] pc_q, pc_d, last_pc_q, last_pc_d;
   logic [DW-1:0] last_ir_q, last_ir_d;
   logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d;
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d, tw_q, tw_d, tr_q, tr_d;
   logic [AW-1:0] tag_q [DEPTH], tag_d [DEPTH], fa_q [DEPTH], fa_d [DEPTH];
   logic [DW-1:0] fd_q [DEPTH], fd_d [DEPTH];
   logic grant, flush, drop, push, pop;

   assign flush    = br_load & ce;
   assign mem_req  = clr & ce & ~br_load & (({1'b0, cnt_q} + {1'b0, outst_q}) < (CW+1)'(DEPTH));
   assign mem_addr = pc_q;
   assign grant    = mem_req & mem_gnt;
   assign drop     = mem_rvalid & (disc_q != '0);
   assign push     = mem_rvalid & ~drop;
   assign ir_valid = cnt_q != '0;
   assign pop      = ir_valid & ir_take & ce;
   assign ir       = ir_valid ? fd_q[rp_q] : last_ir_q;
   assign ir_pc    = ir_valid ? fa_q[rp_q] : last_pc_q;

   always_comb begin
      pc_d      = flush ? br_target : pc_q + AW'(grant);
      outst_d   = outst_q + CW'(grant) - CW'(mem_rvalid);
      disc_d    = flush ? outst_d : disc_q - CW'(drop);
      cnt_d     = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      wp_d      = flush ? rp_q : wp_q + PW'(push);
      rp_d      = flush ? rp_q : rp_q + PW'(pop);
      tw_d      = tw_q + PW'(grant);
      tr_d      = tr_q + PW'(mem_rvalid);
      last_ir_d = pop ? fd_q[rp_q] : last_ir_q;
      last_pc_d = pop ? fa_q[rp_q] : last_pc_q;
      tag_d     = tag_q;
      fa_d      = fa_q;
      fd_d      = fd_q;
      if (grant) tag_d[tw_q] = pc_q;
      if (push) begin
         fa_d[wp_q] = tag_q[tr_q];
         fd_d[wp_q] = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc_q      <= RESET_PC;
         outst_q   <= '0;
         disc_q    <= '0;
         cnt_q     <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         tw_q      <= '0;
         tr_q      <= '0;
         last_ir_q <= '0;
         last_pc_q <= '0;
         tag_q     <= '{default: '0};
         fa_q      <= '{default: '0};
         fd_q      <= '{default: '0};
      end else begin
         pc_q      <= pc_d;
         outst_q   <= outst_d;
         disc_q    <= disc_d;
         cnt_q     <= cnt_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         tw_q      <= tw_d;
         tr_q      <= tr_d;
         last_ir_q <= last_ir_d;
         last_pc_q <= last_pc_d;
         tag_q     <= tag_d;
         fa_q      <= fa_d;
         fd_q      <= fd_d;
         assert (cnt_d <= CW'(DEPTH));
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a latency-1 program memory
// whose responses can be held back to create in-flight requests.
module tb_instr_fetch;
   logic       clk = 0, clr = 0, ce = 1, mem_gnt = 1, ir_take = 0, br_load = 0, resp_en = 1;
   logic       mem_req, mem_rvalid, ir_valid;
   logic [7:0] mem_addr, mem_rdata, ir, ir_pc, br_target = 0;
   int         vectors = 0, miscompares = 0, gcount = 0, g0;
   logic [7:0] q [$];

   instr_fetch dut (
      .clk(clk), .clr(clr), .ce(ce), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc), .ir_take(ir_take),
      .br_load(br_load), .br_target(br_target)
   );

   always #5 clk = ~clk;

   // program contents: address a holds ((a+1) mod 16) << 4
   function automatic logic [7:0] dat(input logic [7:0] a);
      logic [7:0] b;
      b = a + 8'd1;
      return {b[3:0], 4'h0};
   endfunction

   always @(posedge clk or negedge clr)
      if (!clr) begin
         q.delete();
         mem_rvalid <= 1'b0;
         mem_rdata  <= 8'h00;
      end else begin
         if (mem_req && mem_gnt) begin
            q.push_back(mem_addr);
            gcount++;
         end
         if (resp_en && q.size() > 0) begin
            mem_rdata  <= dat(q.pop_front());
            mem_rvalid <= 1'b1;
         end else
            mem_rvalid <= 1'b0;
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 chk("rst_req", mem_req, 0); chk("rst_addr", mem_addr, 0); chk("rst_valid", ir_valid, 0);
      chk("rst_ir", ir, 0); chk("rst_pc", ir_pc, 0);
      // fill without consuming: exactly four grants
      @(negedge clk); clr = 1;
      #1 chk("t1_req0", mem_req, 1); chk("t1_addr0", mem_addr, 0);
      @(negedge clk); #1 chk("t1_addr1", mem_addr, 1); chk("t1_novalid", ir_valid, 0);
      @(negedge clk); #1 chk("t1_valid", ir_valid, 1); chk("t1_ir0", ir, 8'h10); chk("t1_pc0", ir_pc, 0);
      chk("t1_addr2", mem_addr, 2);
      @(negedge clk); #1 chk("t2_req3", mem_req, 1); chk("t2_addr3", mem_addr, 3);
      @(negedge clk); #1 chk("t2_full", mem_req, 0);
      repeat (2) @(negedge clk);
      #1 chk("t2_grants", gcount, 4); chk("t2_req_off", mem_req, 0); chk("t2_hold", ir, 8'h10);
      chk("t2_pc4", mem_addr, 4);
      @(negedge clk); ir_take = 1; #1 chk("t2_ir10", ir, 8'h10); chk("t2_irpc0", ir_pc, 0);
      @(negedge clk); ir_take = 0;
      #1 chk("t1_ir20", ir, 8'h20); chk("t1_pc1", ir_pc, 1); chk("t2_req4", mem_req, 1); chk("t2_addr4", mem_addr, 4);
      @(negedge clk); #1 chk("t2_one_only", mem_req, 0); chk("t2_grants5", gcount, 5);
      @(negedge clk); mem_gnt = 0; ir_take = 1; #1 chk("drain_ir20", ir, 8'h20);
      @(negedge clk); #1 chk("t1_ir30", ir, 8'h30); chk("t1_pc2", ir_pc, 2);
      @(negedge clk); #1 chk("drain_ir40", ir, 8'h40); chk("drain_pc3", ir_pc, 3);
      @(negedge clk); #1 chk("drain_ir50", ir, 8'h50); chk("drain_pc4", ir_pc, 4);
      @(negedge clk); #1 chk("empty_valid", ir_valid, 0); chk("empty_ir", ir, 8'h50); chk("empty_pc", ir_pc, 4);
      @(negedge clk); #1 chk("take_ignored", ir_valid, 0); ir_take = 0;
      // branch with two requests in flight
      @(negedge clk); resp_en = 0; mem_gnt = 1; #1 chk("t3_addr5", mem_addr, 5);
      @(negedge clk); #1 chk("t3_addr6", mem_addr, 6);
      @(negedge clk); br_load = 1; br_target = 8'h40; #1 chk("t3_br_noreq", mem_req, 0);
      @(negedge clk); br_load = 0; resp_en = 1;
      #1 chk("t3_req40", mem_req, 1); chk("t3_addr40", mem_addr, 8'h40); chk("t3_nostale0", ir_valid, 0);
      @(negedge clk); #1 chk("t3_nostale1", ir_valid, 0); chk("t3_addr41", mem_addr, 8'h41);
      @(negedge clk); mem_gnt = 0; #1 chk("t3_nostale2", ir_valid, 0);
      @(negedge clk); #1 chk("t3_nostale3", ir_valid, 0);
      @(negedge clk); #1 chk("t3_valid", ir_valid, 1); chk("t3_ir", ir, 8'h10); chk("t3_pc40", ir_pc, 8'h40);
      @(negedge clk); ir_take = 1; #1 chk("t3_pc40b", ir_pc, 8'h40);
      @(negedge clk); #1 chk("t3_ir2", ir, 8'h20); chk("t3_pc41", ir_pc, 8'h41);
      @(negedge clk); ir_take = 0; #1 chk("t3_empty", ir_valid, 0);
      // stall with one request in flight
      @(negedge clk); mem_gnt = 1; resp_en = 0; #1 chk("t4_addr42", mem_addr, 8'h42);
      @(negedge clk); mem_gnt = 0; ce = 0; resp_en = 1; #1 chk("t4_stall_req", mem_req, 0);
      @(negedge clk); #1 chk("t4_stall_req2", mem_req, 0); chk("t4_novalid", ir_valid, 0);
      @(negedge clk); ir_take = 1; br_load = 1; br_target = 8'h99;
      #1 chk("t4_captured", ir_valid, 1); chk("t4_ir", ir, 8'h30); chk("t4_pc", ir_pc, 8'h42);
      @(negedge clk); ir_take = 0; br_load = 0;
      #1 chk("t4_nopop", ir_valid, 1); chk("t4_ir_hold", ir, 8'h30); chk("t4_br_ignored", mem_addr, 8'h43);
      @(negedge clk); #1 chk("t4_stall_req5", mem_req, 0);
      @(negedge clk); ce = 1; mem_gnt = 1; ir_take = 1;
      #1 chk("t4_resume_req", mem_req, 1); chk("t4_resume_addr", mem_addr, 8'h43); chk("t4_resume_ir", ir, 8'h30);
      @(negedge clk); ir_take = 0; mem_gnt = 0; #1 chk("t4_popped", ir_valid, 0);
      @(negedge clk); #1 chk("t4_next_ir", ir, 8'h40); chk("t4_next_pc", ir_pc, 8'h43); ir_take = 1;
      @(negedge clk); ir_take = 0; #1 chk("t4_empty", ir_valid, 0);
      // address wrap after redirect to 0xFE
      @(negedge clk); br_load = 1; br_target = 8'hFE; #1 chk("t5_br_noreq", mem_req, 0);
      @(negedge clk); br_load = 0; mem_gnt = 1; resp_en = 0; g0 = gcount; #1 chk("t5_fe", mem_addr, 8'hFE);
      @(negedge clk); #1 chk("t5_ff", mem_addr, 8'hFF);
      @(negedge clk); #1 chk("t5_00", mem_addr, 8'h00);
      @(negedge clk); #1 chk("t5_01", mem_addr, 8'h01); chk("t5_req", mem_req, 1);
      @(negedge clk); resp_en = 1; #1 chk("t5_full", mem_req, 0); chk("t5_grants", gcount - g0, 4);
      @(negedge clk); #1 chk("t5_novalid", ir_valid, 0);
      @(negedge clk); ir_take = 1; #1 chk("t5_ir_fe", ir, 8'hF0); chk("t5_pc_fe", ir_pc, 8'hFE);
      @(negedge clk); ir_take = 0;
      #1 chk("t5_pc_ff", ir_pc, 8'hFF); chk("t5_ir_ff", ir, 8'h00); chk("t6_req_pre", mem_req, 1);
      chk("t6_addr_pre", mem_addr, 8'h02);
      // asynchronous reset between clock edges
      #2 clr = 0;
      #1 chk("t6_req", mem_req, 0); chk("t6_valid", ir_valid, 0); chk("t6_ir", ir, 0);
      chk("t6_pc", ir_pc, 0); chk("t6_addr", mem_addr, 0);
      @(negedge clk); clr = 1; #1 chk("t6_restart_req", mem_req, 1); chk("t6_restart_addr", mem_addr, 0);
      repeat (2) @(negedge clk);
      #1 chk("t6_valid2", ir_valid, 1); chk("t6_ir2", ir, 8'h10); chk("t6_pc2", ir_pc, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
